mem_port_arbiter: RTL and testbench

Parametrised N-port memory arbiter that merges the CPU's independent memory request ports (instruction fetch, data access, and later prefetch/DMA) onto one downstream memory/cache port. It is the successor to the fixed two-port split-memory arrangement: the channel count is configurable, grants are round-robin, and each transaction is latched and held until the downstream responds. It sits between the pipeline's memory stages and the unified cache or physical memory.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_rr_select.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the N-port memory arbiter.
// Optional MEM_ARB_FIXED_PRIO_EN (see rr_select) switches round-robin to fixed priority.
package mem_port_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } arb_state_t;

    // Index width that stays legal for any port count >= 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_select.sv
// Combinational winner selection among active channels.
// Round-robin from last_grant+1 by default; MEM_ARB_FIXED_PRIO_EN selects lowest index instead.
module mem_port_arbiter_rr_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IdxW      = 1
) (
    input  logic [NUM_PORTS-1:0] active_i,
    input  logic [IdxW-1:0]      last_grant_i,
    output logic [IdxW-1:0]      winner_o,
    output logic                 valid_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant_i;

    // Descending scan: the last hit is the lowest active index.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (active_i[i]) begin
                winner_o = IdxW'(i);
                valid_o  = 1'b1;
            end
        end
    end
`else
    int unsigned idx;

    // Scan offsets from farthest to nearest so the first channel after last_grant wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
            idx = (32'(last_grant_i) + k) % NUM_PORTS;
            if (active_i[IdxW'(idx)]) begin
                winner_o = IdxW'(idx);
                valid_o  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port memory arbiter: grants one channel, latches its request and holds it until mem_resp_i.
// Arbitration policy is set by MEM_ARB_FIXED_PRIO_EN (undefined: round-robin).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_PORTS-1:0]                   req_read_i,
    input  logic [NUM_PORTS-1:0]                   req_write_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_byte_enable_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   req_address_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NUM_PORTS-1:0]                   req_resp_o,
    output logic [DATA_WIDTH-1:0]                  req_rdata_o,
    output logic                                   mem_read_o,
    output logic                                   mem_write_o,
    output logic [DATA_WIDTH/8-1:0]                mem_byte_enable_o,
    output logic [ADDR_WIDTH-1:0]                  mem_address_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_resp_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i
);

    localparam int unsigned IdxW = idx_width(NUM_PORTS);
    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam logic [IdxW-1:0] LastGrantInit = IdxW'(NUM_PORTS - 1);

    arb_state_t             state_q, state_d;
    logic [IdxW-1:0]        grant_q, grant_d;
    logic [IdxW-1:0]        last_grant_q, last_grant_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;
    logic [BeW-1:0]         be_q, be_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

    logic [NUM_PORTS-1:0]   active;
    logic [IdxW-1:0]        winner;
    logic                   win_valid;
    logic                   busy;
    logic                   done;

    assign active = req_read_i | req_write_i;

    mem_port_arbiter_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IdxW      (IdxW)
    ) u_rr_select (
        .active_i     (active),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .valid_o      (win_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        read_d       = read_q;
        write_d      = write_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StBusy;
                    grant_d = winner;
                    write_d = req_write_i[winner];
                    // Write wins when a channel raises both strobes.
                    read_d  = req_read_i[winner] & ~req_write_i[winner];
                    be_d    = req_byte_enable_i[winner];
                    addr_d  = req_address_i[winner];
                    wdata_d = req_wdata_i[winner];
                end
            end
            StBusy: begin
                if (mem_resp_i) begin
                    state_d      = StIdle;
                    last_grant_d = grant_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LastGrantInit;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            read_q       <= read_d;
            write_q      <= write_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign done = busy & mem_resp_i;

    assign mem_read_o        = busy & read_q;
    assign mem_write_o       = busy & write_q;
    assign mem_byte_enable_o = be_q;
    assign mem_address_o     = addr_q;
    assign mem_wdata_o       = wdata_q;
    assign req_rdata_o       = done ? mem_rdata_i : '0;

    always_comb begin
        req_resp_o = '0;
        if (done) begin
            req_resp_o[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (4 ports), directed scenarios plus randomized traffic.
// Honors MEM_ARB_FIXED_PRIO_EN in its reference model.
module tb_mem_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          req_read;
    logic [NP-1:0]          req_write;
    logic [NP-1:0][BW-1:0]  req_be;
    logic [NP-1:0][AW-1:0]  req_addr;
    logic [NP-1:0][DW-1:0]  req_wdata;
    logic [NP-1:0]          req_resp;
    logic [DW-1:0]          req_rdata;
    logic                   mem_read;
    logic                   mem_write;
    logic [BW-1:0]          mem_be;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic                   mem_resp;
    logic [DW-1:0]          mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_last;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_read_i        (req_read),
        .req_write_i       (req_write),
        .req_byte_enable_i (req_be),
        .req_address_i     (req_addr),
        .req_wdata_i       (req_wdata),
        .req_resp_o        (req_resp),
        .req_rdata_o       (req_rdata),
        .mem_read_o        (mem_read),
        .mem_write_o       (mem_write),
        .mem_byte_enable_o (mem_be),
        .mem_address_o     (mem_addr),
        .mem_wdata_o       (mem_wdata),
        .mem_resp_i        (mem_resp),
        .mem_rdata_i       (mem_rdata)
    );

    // Winner per the arbitration rule: first active channel after the last grant.
    function automatic int pick(input logic [NP-1:0] act, input int last);
        if (FixedPrio) begin
            for (int i = 0; i < NP; i++) if (act[i]) return i;
            return -1;
        end
        for (int k = 1; k <= NP; k++) begin
            if (act[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        req_read  = '0;
        req_write = '0;
        req_be    = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = NP - 1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_read  = '1;
        req_write = 4'b0101;
        req_be    = '1;
        req_addr  = '1;
        req_wdata = '1;
        mem_resp  = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++; if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
        tests_run++; if (mem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
        tests_run++; if (req_resp !== 4'b0) begin tests_failed++; $display("FAIL reset_req_resp got %b want 0000", req_resp); end
        tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_address got %h want 0", mem_addr); end
        tests_run++; if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        tests_run++; if (mem_be !== 4'h0) begin tests_failed++; $display("FAIL reset_mem_byte_enable got %h want 0", mem_be); end
        tests_run++; if (req_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_req_rdata got %h want 0", req_rdata); end
        idle_inputs();
        rst = 1'b0;
        model_last = NP - 1;
    endtask

    task automatic test_single_read();
        do_reset();
        req_read[1] = 1'b1;
        req_addr[1] = 32'h0000_0040;
        req_be[1]   = 4'hF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) begin
                mem_resp  = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            tests_run++; if (mem_read !== 1'b1) begin tests_failed++; $display("FAIL single_rd_strobe c=%0d got %b want 1", c, mem_read); end
            tests_run++; if (mem_addr !== 32'h40) begin tests_failed++; $display("FAIL single_rd_addr c=%0d got %h want 00000040", c, mem_addr); end
            tests_run++;
            if (req_resp !== ((c == 3) ? 4'b0010 : 4'b0000)) begin
                tests_failed++; $display("FAIL single_rd_resp c=%0d got %b want %b", c, req_resp, (c == 3) ? 4'b0010 : 4'b0000);
            end
        end
        tests_run++; if (req_rdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL single_rd_rdata got %h want deadbeef", req_rdata); end
        @(negedge clk);
        mem_resp    = 1'b0;
        req_read[1] = 1'b0;
        #1;
        tests_run++; if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL single_rd_after got %b want 0", mem_read); end
        tests_run++; if (req_resp !== 4'b0) begin tests_failed++; $display("FAIL single_rd_resp_after got %b want 0000", req_resp); end
    endtask

    task automatic test_contention();
        do_reset();
        req_read[0]  = 1'b1;
        req_addr[0]  = 32'h100;
        req_be[0]    = 4'hF;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h200;
        req_wdata[1] = 32'hCAFE_F00D;
        req_be[1]    = 4'hF;
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = 32'h1111_1111;
        #1;
        tests_run++; if (req_resp !== 4'b0001) begin tests_failed++; $display("FAIL contend_first_resp got %b want 0001", req_resp); end
        tests_run++; if (mem_addr !== 32'h100) begin tests_failed++; $display("FAIL contend_first_addr got %h want 00000100", mem_addr); end
        tests_run++; if (mem_read !== 1'b1) begin tests_failed++; $display("FAIL contend_first_read got %b want 1", mem_read); end
        @(negedge clk);
        mem_resp    = 1'b0;
        req_read[0] = 1'b0;
        #1;
        tests_run++; if ((mem_read | mem_write) !== 1'b0) begin tests_failed++; $display("FAIL contend_idle_gap got %b want 0", mem_read | mem_write); end
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        tests_run++; if (mem_write !== 1'b1) begin tests_failed++; $display("FAIL contend_second_write got %b want 1", mem_write); end
        tests_run++; if (mem_addr !== 32'h200) begin tests_failed++; $display("FAIL contend_second_addr got %h want 00000200", mem_addr); end
        tests_run++; if (mem_wdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL contend_wdata got %h want cafef00d", mem_wdata); end
        tests_run++; if (mem_be !== 4'hF) begin tests_failed++; $display("FAIL contend_be got %h want f", mem_be); end
        tests_run++; if (req_resp !== 4'b0010) begin tests_failed++; $display("FAIL contend_second_resp got %b want 0010", req_resp); end
        @(negedge clk);
        mem_resp     = 1'b0;
        req_write[1] = 1'b0;
    endtask

    task automatic test_read_write_same_port();
        req_read[2]  = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h300;
        req_wdata[2] = 32'h1234_5678;
        req_be[2]    = 4'h3;
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        tests_run++; if (mem_write !== 1'b1) begin tests_failed++; $display("FAIL rw_write got %b want 1", mem_write); end
        tests_run++; if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL rw_read_dropped got %b want 0", mem_read); end
        tests_run++; if (mem_wdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL rw_wdata got %h want 12345678", mem_wdata); end
        tests_run++; if (mem_addr !== 32'h300) begin tests_failed++; $display("FAIL rw_addr got %h want 00000300", mem_addr); end
        tests_run++; if (req_resp !== 4'b0100) begin tests_failed++; $display("FAIL rw_resp got %b want 0100", req_resp); end
        @(negedge clk);
        mem_resp     = 1'b0;
        req_read[2]  = 1'b0;
        req_write[2] = 1'b0;
    endtask

    task automatic test_input_stability();
        do_reset();
        req_read[0] = 1'b1;
        req_addr[0] = 32'hA0;
        req_be[0]   = 4'hC;
        @(negedge clk);
        req_addr[0] = 32'hB0;
        #1;
        tests_run++; if (mem_addr !== 32'hA0) begin tests_failed++; $display("FAIL stable_addr_1 got %h want 000000a0", mem_addr); end
        @(negedge clk);
        req_addr[0] = 32'hC0;
        req_be[0]   = 4'h1;
        mem_resp    = 1'b1;
        #1;
        tests_run++; if (mem_addr !== 32'hA0) begin tests_failed++; $display("FAIL stable_addr_2 got %h want 000000a0", mem_addr); end
        tests_run++; if (mem_be !== 4'hC) begin tests_failed++; $display("FAIL stable_be got %h want c", mem_be); end
        tests_run++; if (req_resp !== 4'b0001) begin tests_failed++; $display("FAIL stable_resp got %b want 0001", req_resp); end
        @(negedge clk);
        mem_resp    = 1'b0;
        req_read[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_write[3] = 1'b1;
        req_addr[3]  = 32'h3C0;
        req_wdata[3] = 32'h5A5A_0001;
        req_be[3]    = 4'hF;
        @(negedge clk);
        #1;
        tests_run++; if (mem_write !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy got %b want 1", mem_write); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        tests_run++; if (req_resp !== 4'b0) begin tests_failed++; $display("FAIL midrst_resp got %b want 0000", req_resp); end
        tests_run++; if ((mem_read | mem_write) !== 1'b0) begin tests_failed++; $display("FAIL midrst_strobes got %b want 0", mem_read | mem_write); end
        tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL midrst_addr got %h want 0", mem_addr); end
        tests_run++; if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL midrst_wdata got %h want 0", mem_wdata); end
        tests_run++; if (req_rdata !== 32'h0) begin tests_failed++; $display("FAIL midrst_rdata got %h want 0", req_rdata); end
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        tests_run++; if (mem_write !== 1'b1) begin tests_failed++; $display("FAIL midrst_rearb_write got %b want 1", mem_write); end
        tests_run++; if (mem_addr !== 32'h3C0) begin tests_failed++; $display("FAIL midrst_rearb_addr got %h want 000003c0", mem_addr); end
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        tests_run++; if (req_resp !== 4'b1000) begin tests_failed++; $display("FAIL midrst_rearb_resp got %b want 1000", req_resp); end
        @(negedge clk);
        mem_resp     = 1'b0;
        req_write[3] = 1'b0;
    endtask

    task automatic test_fairness();
        int exp;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            req_read[p] = 1'b1;
            req_addr[p] = 32'(p) << 4;
            req_be[p]   = 4'hF;
        end
        for (int n = 0; n < 3 * NP; n++) begin
            exp = FixedPrio ? 0 : n % NP;
            @(negedge clk);
            mem_resp = 1'b1;
            #1;
            tests_run++; if (mem_addr !== (32'(exp) << 4)) begin tests_failed++; $display("FAIL fair_order n=%0d got addr %h want port %0d", n, mem_addr, exp); end
            tests_run++; if (req_resp !== (4'b0001 << exp)) begin tests_failed++; $display("FAIL fair_resp n=%0d got %b want port %0d", n, req_resp, exp); end
            @(negedge clk);
            mem_resp = 1'b0;
            #1;
            tests_run++; if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL fair_idle_gap n=%0d got %b want 0", n, mem_read); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [NP-1:0] act;
        int            served;
        int            exp;
        int            lat;
        int            kind;
        logic [DW-1:0] rd;
        logic          exp_rd;
        logic          exp_wr;
        do_reset();
        served = -1;
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            mem_resp = 1'b0;
            if (served >= 0) begin
                req_read[served]  = 1'b0;
                req_write[served] = 1'b0;
                model_last        = served;
            end
            for (int p = 0; p < NP; p++) begin
                if (p != served && !(req_read[p] | req_write[p]) && $urandom_range(0, 1) == 1) begin
                    kind         = $urandom_range(0, 2);
                    req_read[p]  = (kind != 1);
                    req_write[p] = (kind != 0);
                    req_addr[p]  = $urandom;
                    req_wdata[p] = $urandom;
                    req_be[p]    = BW'($urandom);
                end
            end
            served   = -1;
            mem_resp = ($urandom_range(0, 3) == 0);
            #1;
            tests_run++; if (req_resp !== 4'b0) begin tests_failed++; $display("FAIL rand_idle_resp it=%0d got %b want 0000", it, req_resp); end
            tests_run++; if ((mem_read | mem_write) !== 1'b0) begin tests_failed++; $display("FAIL rand_idle_strobe it=%0d got %b want 0", it, mem_read | mem_write); end
            act = req_read | req_write;
            exp = pick(act, model_last);
            if (exp >= 0) begin
                exp_wr = req_write[exp];
                exp_rd = req_read[exp] & ~req_write[exp];
                lat    = $urandom_range(1, 4);
                for (int c = 1; c <= lat; c++) begin
                    @(negedge clk);
                    mem_resp = (c == lat);
                    rd       = $urandom;
                    mem_rdata = rd;
                    #1;
                    tests_run++;
                    if ({mem_read, mem_write} !== {exp_rd, exp_wr}) begin
                        tests_failed++; $display("FAIL rand_strobes it=%0d got %b%b want %b%b", it, mem_read, mem_write, exp_rd, exp_wr);
                    end
                    tests_run++;
                    if ({mem_addr, mem_wdata, mem_be} !== {req_addr[exp], req_wdata[exp], req_be[exp]}) begin
                        tests_failed++; $display("FAIL rand_payload it=%0d got %h/%h/%h want %h/%h/%h", it, mem_addr, mem_wdata, mem_be, req_addr[exp], req_wdata[exp], req_be[exp]);
                    end
                    tests_run++;
                    if (req_resp !== ((c == lat) ? (4'b0001 << exp) : 4'b0000)) begin
                        tests_failed++; $display("FAIL rand_resp it=%0d c=%0d got %b want port %0d at end", it, c, req_resp, exp);
                    end
                    if (c == lat && exp_rd) begin
                        tests_run++;
                        if (req_rdata !== rd) begin tests_failed++; $display("FAIL rand_rdata it=%0d got %h want %h", it, req_rdata, rd); end
                    end
                end
                served = exp;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_last = NP - 1;
        test_reset();
        test_single_read();
        test_contention();
        test_read_write_same_port();
        test_input_stability();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
